// File: rtl/tone_recorder.sv
// Tone recorder: measures a square wave on tone_in and writes {period_us, duration_ms} note records.
// Defining TONE_RECORDER_GLITCH_FILTER_EN inserts a 4-sample stability filter ahead of edge detection.

module tone_recorder #(
  parameter int CLK_FREQ    = 50000000,
  parameter int MEMORY_SIZE = 4096,
  parameter int SILENCE_US  = 50000,
  parameter int TOL_US      = 8,
  localparam int ADDR_W     = $clog2(MEMORY_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              tone_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W-1:0] note_count
);

  localparam int US_DIV = CLK_FREQ / 1000000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE - 1);
  localparam logic [15:0] SIL_M1 = 16'(SILENCE_US - 1);

  typedef enum logic [2:0] {IDLE, ARM0, ARM1, RECORD, FLUSH, TERM} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic near(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= $signed(17'(TOL_US));
  endfunction

  state_t            state, state_nxt;
  logic              sync1, sync2, tone_s, tone_prev, rise;
  logic [US_W-1:0]   us_cnt;
  logic [9:0]        ms_cnt;
  logic              us_wrap, us_tick, ms_tick;
  logic [15:0]       period_cnt, meas, cur, cur_nxt, dur;
  logic              sil_hit, silent, begin_sess;
  logic              want_rec, rec_wr, term_wr, full_hit, load_cur, dur_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      tone_prev <= 1'b0;
    end else begin
      sync1     <= tone_in;
      sync2     <= sync1;
      tone_prev <= tone_s;
    end
  end

`ifdef TONE_RECORDER_GLITCH_FILTER_EN
  // Output follows the input only once four consecutive samples agree.
  logic [2:0] hist;
  logic       filt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= 3'b000;
      filt <= 1'b0;
    end else begin
      hist <= {hist[1:0], sync2};
      if ((hist == {3{sync2}})) filt <= sync2;
    end
  end
  assign tone_s = filt;
`else
  assign tone_s = sync2;
`endif

  assign rise       = tone_s & ~tone_prev;
  assign begin_sess = (state == IDLE) && start;
  assign us_wrap    = (us_cnt == US_W'(US_DIV - 1));
  assign us_tick    = busy & us_wrap;
  assign ms_tick    = us_tick && (ms_cnt == 10'd999);
  assign meas       = (period_cnt == 16'd0) ? 16'd1 : period_cnt;
  assign silent     = sil_hit & ~rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us_cnt     <= '0;
      ms_cnt     <= '0;
      period_cnt <= '0;
      sil_hit    <= 1'b0;
      dur        <= '0;
    end else begin
      if (!busy) begin
        us_cnt <= '0;
        ms_cnt <= '0;
      end else begin
        us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
        if (us_tick) ms_cnt <= (ms_cnt == 10'd999) ? 10'd0 : ms_cnt + 10'd1;
      end
      if (rise || begin_sess) period_cnt <= '0;
      else if (us_tick)       period_cnt <= sat_inc(period_cnt);
      // One-cycle pulse in the cycle period_cnt first equals SILENCE_US.
      sil_hit <= us_tick && !rise && !begin_sess && (period_cnt == SIL_M1);
      if (dur_clr || begin_sess) dur <= '0;
      else if (ms_tick)          dur <= sat_inc(dur);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    want_rec  = 1'b0;
    term_wr   = 1'b0;
    load_cur  = 1'b0;
    cur_nxt   = cur;
    dur_clr   = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = ARM0;
      ARM0: begin
        if (stop)      state_nxt = TERM;
        else if (rise) state_nxt = ARM1;
      end
      ARM1: begin
        if (stop) state_nxt = TERM;
        else if (rise) begin
          state_nxt = RECORD;
          load_cur  = 1'b1;
          cur_nxt   = meas;
          dur_clr   = 1'b1;
        end else if (silent) state_nxt = ARM0;
      end
      RECORD: begin
        if (stop) state_nxt = FLUSH;
        else if (cur != 16'd0) begin
          if (rise && !near(meas, cur)) begin
            want_rec = 1'b1;
            load_cur = 1'b1;
            cur_nxt  = meas;
            dur_clr  = 1'b1;
          end else if (silent) begin
            want_rec = 1'b1;
            load_cur = 1'b1;
            cur_nxt  = 16'd0;
            dur_clr  = 1'b1;
          end
        end else if (rise) begin
          want_rec  = 1'b1;
          state_nxt = ARM1;
        end
      end
      FLUSH: begin
        state_nxt = TERM;
        want_rec  = (dur != 16'd0);
      end
      TERM: begin
        term_wr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The last word is reserved for the terminator: a record landing there ends the session.
    full_hit = want_rec && (mem_addr == LAST_ADDR);
    if (full_hit) begin
      term_wr   = 1'b1;
      state_nxt = IDLE;
    end
    rec_wr   = want_rec && !full_hit;
    mem_we   = rec_wr || term_wr;
    mem_data = rec_wr ? {cur, dur} : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      mem_addr   <= '0;
      note_count <= '0;
    end else begin
      if (load_cur) cur <= cur_nxt;
      if (begin_sess) begin
        busy       <= 1'b1;
        full       <= 1'b0;
        mem_addr   <= '0;
        note_count <= '0;
      end
      if (rec_wr) begin
        mem_addr   <= mem_addr + 1'b1;
        note_count <= note_count + 1'b1;
      end
      if (full_hit) full <= 1'b1;
      if (term_wr)  busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_recorder.sv
// Directed bench for tone_recorder at 2 MHz (2 cycles per us) with a 4-word note memory.

module tb_tone_recorder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              tone_in = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              busy;
  logic              full;
  logic [ADDR_W-1:0] note_count;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [31:0]       log_data [0:63];
  int nw = 0;

  tone_recorder #(
    .CLK_FREQ(2000000), .MEMORY_SIZE(4), .SILENCE_US(1000), .TOL_US(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tone_in(tone_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .full(full), .note_count(note_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (nw < 64) begin
        log_addr[nw] = mem_addr;
        log_data[nw] = mem_data;
      end
      nw = nw + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  // Square wave: period p us = p cycles high then p cycles low.
  task automatic tone(input int p, input int n);
    repeat (n) begin
      tone_in = 1'b1; cyc(p);
      tone_in = 1'b0; cyc(p);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk); k++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s_busy: busy=%b after %0d cycles, required 0", name, busy, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cyc(3);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b, required 0", mem_we); end
    tests++; if (mem_addr !== 2'd0) begin fails++; $display("FAIL reset_addr: got %0d, required 0", mem_addr); end
    tests++; if (mem_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h, required 0", mem_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", full); end
    tests++; if (note_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d, required 0", note_count); end
    reset = 1'b1; cyc(2);
  endtask

  task automatic test_idle_stop();
    int base;
    base = nw;
    pulse_stop(); tone(10, 3); cyc(50);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_stop_busy: got %b, required 0", busy); end
    tests++; if (nw - base !== 0) begin fails++; $display("FAIL idle_stop_writes: got %0d, required 0", nw - base); end
  endtask

  task automatic test_single_note();
    int base;
    logic [31:0] w;
    base = nw;
    pulse_start(); tone(100, 25);
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_mid: got %b, required 1", busy); end
    tone(100, 25); cyc(200); pulse_stop(); wait_idle("single");
    tests++; if (nw - base !== 2) begin fails++; $display("FAIL single_nwrites: got %0d, required 2", nw - base); end
    w = log_data[base];
    tests++; if (log_addr[base] !== 2'd0) begin fails++; $display("FAIL single_addr0: got %0d, required 0", log_addr[base]); end
    tests++; if (((w[31:16] >= 16'd99) && (w[31:16] <= 16'd100)) !== 1'b1) begin fails++; $display("FAIL single_period: got %0d, required 99..100", w[31:16]); end
    tests++; if (w[15:0] !== 16'd5) begin fails++; $display("FAIL single_dur: got %0d, required 5", w[15:0]); end
    tests++; if (log_addr[base+1] !== 2'd1 || log_data[base+1] !== 32'h0) begin fails++; $display("FAIL single_term: got addr %0d data %h, required addr 1 data 0", log_addr[base+1], log_data[base+1]); end
    tests++; if (note_count !== 2'd1) begin fails++; $display("FAIL single_count: got %0d, required 1", note_count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL single_full: got %b, required 0", full); end
  endtask

  task automatic test_tone_silence_tone();
    int base;
    logic [31:0] w;
    base = nw;
    pulse_start(); tone(200, 20); cyc(5000); tone(100, 40); cyc(200); pulse_stop(); wait_idle("multi");
    tests++; if (nw - base !== 4) begin fails++; $display("FAIL multi_nwrites: got %0d, required 4", nw - base); end
    w = log_data[base];
    tests++; if (((w[31:16] >= 16'd199) && (w[31:16] <= 16'd200) && (w[15:0] == 16'd4)) !== 1'b1) begin fails++; $display("FAIL multi_rec0: got %0d/%0d, required 199..200/4", w[31:16], w[15:0]); end
    w = log_data[base+1];
    tests++; if (w !== {16'd0, 16'd2} || log_addr[base+1] !== 2'd1) begin fails++; $display("FAIL multi_rest: got %h at %0d, required 00000002 at 1", w, log_addr[base+1]); end
    w = log_data[base+2];
    tests++; if (((w[31:16] >= 16'd99) && (w[31:16] <= 16'd100) && (w[15:0] == 16'd4)) !== 1'b1) begin fails++; $display("FAIL multi_rec2: got %0d/%0d, required 99..100/4", w[31:16], w[15:0]); end
    tests++; if (log_addr[base+3] !== 2'd3 || log_data[base+3] !== 32'h0) begin fails++; $display("FAIL multi_term: got addr %0d data %h, required addr 3 data 0", log_addr[base+3], log_data[base+3]); end
    tests++; if (note_count !== 2'd3) begin fails++; $display("FAIL multi_count: got %0d, required 3", note_count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL multi_full: got %b, required 0", full); end
  endtask

  task automatic test_jitter_step();
    int base;
    logic [31:0] w;
    base = nw;
    pulse_start();
    repeat (5) begin
      tone(100, 1); tone(105, 1); tone(95, 1); tone(104, 1); tone(96, 1); tone(100, 1);
    end
    tone(115, 20); cyc(200); pulse_stop(); wait_idle("jitter");
    tests++; if (nw - base !== 3) begin fails++; $display("FAIL jitter_nwrites: got %0d, required 3", nw - base); end
    w = log_data[base];
    tests++; if (((w[31:16] >= 16'd99) && (w[31:16] <= 16'd100) && (w[15:0] == 16'd3)) !== 1'b1) begin fails++; $display("FAIL jitter_rec0: got %0d/%0d, required 99..100/3", w[31:16], w[15:0]); end
    w = log_data[base+1];
    tests++; if (((w[31:16] >= 16'd114) && (w[31:16] <= 16'd115) && (w[15:0] == 16'd2)) !== 1'b1) begin fails++; $display("FAIL jitter_rec1: got %0d/%0d, required 114..115/2", w[31:16], w[15:0]); end
    tests++; if (log_addr[base+2] !== 2'd2 || log_data[base+2] !== 32'h0) begin fails++; $display("FAIL jitter_term: got addr %0d data %h, required addr 2 data 0", log_addr[base+2], log_data[base+2]); end
    tests++; if (note_count !== 2'd2) begin fails++; $display("FAIL jitter_count: got %0d, required 2", note_count); end
  endtask

  task automatic test_full();
    int base;
    logic [31:0] w;
    base = nw;
    pulse_start();
    tone(100, 1); tone(200, 1); tone(100, 1); tone(200, 1); tone(100, 1); tone(200, 1); tone(100, 1);
    cyc(20);
    tests++; if (nw - base !== 4) begin fails++; $display("FAIL full_nwrites: got %0d, required 4", nw - base); end
    w = log_data[base];
    tests++; if ((log_addr[base] == 2'd0 && w[31:16] >= 16'd99 && w[31:16] <= 16'd100 && w[15:0] == 16'd0) !== 1'b1) begin fails++; $display("FAIL full_rec0: got %h at %0d, required 99..100/0 at 0", w, log_addr[base]); end
    w = log_data[base+1];
    tests++; if ((log_addr[base+1] == 2'd1 && w[31:16] >= 16'd199 && w[31:16] <= 16'd200 && w[15:0] == 16'd0) !== 1'b1) begin fails++; $display("FAIL full_rec1: got %h at %0d, required 199..200/0 at 1", w, log_addr[base+1]); end
    w = log_data[base+2];
    tests++; if ((log_addr[base+2] == 2'd2 && w[31:16] >= 16'd99 && w[31:16] <= 16'd100 && w[15:0] == 16'd0) !== 1'b1) begin fails++; $display("FAIL full_rec2: got %h at %0d, required 99..100/0 at 2", w, log_addr[base+2]); end
    tests++; if (log_addr[base+3] !== 2'd3 || log_data[base+3] !== 32'h0) begin fails++; $display("FAIL full_term: got addr %0d data %h, required addr 3 data 0", log_addr[base+3], log_data[base+3]); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b, required 1", full); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy: got %b, required 0", busy); end
    tests++; if (note_count !== 2'd3) begin fails++; $display("FAIL full_count: got %0d, required 3", note_count); end
  endtask

  task automatic test_stop_in_arm();
    int base;
    base = nw;
    pulse_start();
    tests++; if (full !== 1'b0 || mem_addr !== 2'd0 || note_count !== 2'd0) begin fails++; $display("FAIL arm_start_clear: got full %b addr %0d count %0d, required 0 0 0", full, mem_addr, note_count); end
    tone_in = 1'b1; cyc(20); pulse_stop(); tone_in = 1'b0; wait_idle("arm");
    tests++; if (nw - base !== 1) begin fails++; $display("FAIL arm_nwrites: got %0d, required 1", nw - base); end
    tests++; if (log_addr[base] !== 2'd0 || log_data[base] !== 32'h0) begin fails++; $display("FAIL arm_term: got addr %0d data %h, required addr 0 data 0", log_addr[base], log_data[base]); end
    tests++; if (note_count !== 2'd0) begin fails++; $display("FAIL arm_count: got %0d, required 0", note_count); end
  endtask

  task automatic test_reset_mid_record();
    int base;
    base = nw;
    pulse_start(); tone(100, 3); tone(200, 3);
    tests++; if (nw - base !== 1 || note_count !== 2'd1) begin fails++; $display("FAIL rst_pre: got %0d writes count %0d, required 1 and 1", nw - base, note_count); end
    reset = 1'b0; #1;
    tests++; if (mem_we !== 1'b0 || mem_data !== 32'h0) begin fails++; $display("FAIL rst_we_data: got we %b data %h, required 0 0", mem_we, mem_data); end
    tests++; if (mem_addr !== 2'd0 || note_count !== 2'd0) begin fails++; $display("FAIL rst_addr_count: got addr %0d count %0d, required 0 0", mem_addr, note_count); end
    tests++; if (busy !== 1'b0 || full !== 1'b0) begin fails++; $display("FAIL rst_busy_full: got busy %b full %b, required 0 0", busy, full); end
    cyc(5); reset = 1'b1;
    tone(100, 10); cyc(3000);
    tests++; if (nw - base !== 1) begin fails++; $display("FAIL rst_no_writes: got %0d writes, required 1", nw - base); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_post_busy: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_idle_stop();
    test_single_note();
    test_tone_silence_tone();
    test_jitter_step();
    test_full();
    test_stop_in_arm();
    test_reset_mid_record();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
